snitch_acc_offload: RTL and testbench
=====================================

Name: snitch_acc_offload

Overview:
- Core-side initiator for the accelerator request/response interface: takes offloaded instructions (M-extension and similar) from the integer core and issues them on the q-channel with a registered output stage.
- Tracks outstanding destination registers in a 32-entry scoreboard and answers operand hazard queries from the core.
- Accepts p-channel responses and turns them into register-file writebacks.
- Sits between the core decode/issue stage and a shared accelerator such as the shared mul/div unit.

Parameters:
- IdWidth, 5, width of acc_qid_o/acc_pid_i; must be ≥5 because the id carries rd.
- MaxOutstanding, 4, maximum in-flight requests (issued, not yet written back); range 1..31.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- off_valid_i  in  1  core offers an instruction
- off_ready_o  out  1  instruction accepted when both high
- off_instr_i  in  32  RISC-V instruction word
- off_arga_i / off_argb_i / off_argc_i  in  32 each  operands
- off_rd_i  in  5  destination register
- hz_rs_i  in  15  three packed source register indices {rs3,rs2,rs1}
- hz_use_i  in  3  per-source valid flags
- hz_stall_o  out  1  any used source (or off_rd_i while off_valid_i) is pending
- acc_qaddr_o  out  32  constant 0
- acc_qid_o  out  IdWidth  zero-extended rd
- acc_qdata_op_o / acc_qdata_arga_o / acc_qdata_argb_o / acc_qdata_argc_o  out  32 each  registered request payload
- acc_qvalid_o  out  1  request valid
- acc_qready_i  in  1  accelerator accepts the request
- acc_pdata_i  in  32  response data
- acc_pid_i  in  IdWidth  response id
- acc_perror_i  in  1  response error
- acc_pvalid_i  in  1  response valid
- acc_pready_o  out  1  response accepted
- wb_valid_o  out  1  writeback request
- wb_ready_i  in  1  register file port granted
- wb_rd_o  out  5  acc_pid_i[4:0]
- wb_data_o  out  32  acc_pdata_i
- err_o  out  1  sticky error flag

Behaviour:
- Reset values: acc_qvalid_o=0, all q payload=0, scoreboard=0, outstanding count=0, err_o=0.
- q-stage: a single register slot.
  - can_load = !acc_qvalid_o | acc_qready_i.
  - off_ready_o = can_load & !sb[off_rd_i] & (cnt < MaxOutstanding) & !hz_stall_o.
- On off_valid_i & off_ready_o:
  - Load the payload; acc_qvalid_o=1 next cycle (issue latency 1 cycle).
  - Set sb[off_rd_i]; cnt+1.
- If acc_qready_i with no new load, acc_qvalid_o clears. Payload holds stable while acc_qvalid_o & !acc_qready_i.
- rd=x0: still issued and tracked. The sb[0] bit is set and cleared normally; hazard checks on x0 always return 0.
- Hazard check: hz_stall_o = OR over i of (hz_use_i[i] & sb[rs_i] & rs_i!=0) | (off_valid_i & sb[off_rd_i] & off_rd_i!=0). Combinational from the registered scoreboard only.
- p-channel pass-through, zero buffering:
  - wb_valid_o = acc_pvalid_i; acc_pready_o = wb_ready_i.
  - On acc_pvalid_i & wb_ready_i: clear sb[pid[4:0]]; cnt-1.
- Simultaneous issue and retire:
  - The same rd cannot be issued in the retire cycle, because the check uses the registered sb.
  - For different rds, set and clear both apply.
  - cnt changes by net 0 when both happen.
- err_o set (sticky until reset) on any of:
  - a completed response with acc_perror_i=1 (writeback still performed);
  - a response whose sb bit is clear (spurious; still written back, cnt not decremented);
  - a response with pid[IdWidth-1:5] != 0.
- cnt never wraps: decrement is suppressed at 0, and increment is impossible at MaxOutstanding by construction.
- Reset mid-operation: all state clears asynchronously. Responses arriving after reset are treated as spurious.

Optional Feature:
- SNITCH_ACC_OFFLOAD_PERF_EN defined: adds outputs perf_issued_o (32-bit wrapping count of q handshakes) and perf_stall_o (32-bit wrapping count of cycles with off_valid_i & !off_ready_o). Both reset to 0.
- Not defined: these ports and counters are absent.

Decomposition:
- Package snitch_acc_pkg holds:
  - acc_req_t struct {addr, id, data_op, data_arga, data_argb, data_argc};
  - acc_rsp_t struct {data, id, error};
  - constant NumRegs=32.
- One natural sub-module: snitch_acc_scoreboard, containing the 32-bit set/clear vector, the three-port pending lookup and the outstanding counter.

Test Plan:
- Single issue: MUL rd=5, a=3, b=7 accepted at cycle 0 → acc_qvalid_o=1 at cycle 1 with id=5. Response pid=5, data=21 → wb_rd_o=5, wb_data_o=21, sb[5] clears, cnt back to 0.
- Backpressure: acc_qready_i=0 for 4 cycles after issue → payload stable, off_ready_o=0 for a second rd=6 request; it issues the cycle after acc_qready_i rises.
- RAW hazard: DIV rd=8 in flight, hz_use_i=001 with rs1=8 → hz_stall_o=1 until the pid=8 writeback completes, then 0 the next cycle.
- Credit limit: MaxOutstanding=4, issue rds 1..4 with no responses → 5th request stalls. Retire rd 2 → 5th issues on the next cycle.
- Error and spurious response: response pid=9 with sb[9]=0, then a valid response with acc_perror_i=1 → err_o goes high and stays high, writebacks are still emitted, and cnt is unchanged by the spurious response.
- Reset while 3 requests are outstanding and acc_qvalid_o=1 → all outputs return to reset values immediately, and the next issue proceeds normally.

Source files
------------

// File: rtl/snitch_acc_pkg.sv
// Shared types for the accelerator offload interface: request/response payloads and register index helpers.
package snitch_acc_pkg;

  localparam int unsigned NumRegs     = 32;
  localparam int unsigned RegIdxWidth = 5;
  localparam int unsigned NumSrcRegs  = 3;

  typedef logic [RegIdxWidth-1:0] reg_idx_t;

  typedef struct packed {
    logic [31:0] addr;
    reg_idx_t    id;
    logic [31:0] data_op;
    logic [31:0] data_arga;
    logic [31:0] data_argb;
    logic [31:0] data_argc;
  } acc_req_t;

  typedef struct packed {
    logic [31:0] data;
    reg_idx_t    id;
    logic        error;
  } acc_rsp_t;

  function automatic logic [NumRegs-1:0] reg_mask(input reg_idx_t idx);
    return {{(NumRegs-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/snitch_acc_scoreboard.sv
// Pending-destination scoreboard with source hazard lookup and an outstanding-request counter.
// Lookups read only the registered vector, so a register retiring this cycle still reads as pending.
module snitch_acc_scoreboard
  import snitch_acc_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              set,
  input  reg_idx_t                          set_idx,
  input  logic                              clr,
  input  reg_idx_t                          clr_idx,
  input  logic [NumSrcRegs*RegIdxWidth-1:0] rs,
  input  logic [NumSrcRegs-1:0]             rs_use,
  input  logic                              chk_vld,
  input  reg_idx_t                          chk_idx,
  output logic                              chk_busy,
  output logic                              clr_hit,
  output logic                              hazard,
  output logic                              full
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  logic [NumRegs-1:0]  sb_q;
  logic [NumRegs-1:0]  sb_d;
  logic [CntWidth-1:0] cnt_q;
  logic                cnt_inc;
  logic                cnt_dec;

  assign chk_busy = sb_q[chk_idx];
  assign clr_hit  = sb_q[clr_idx];
  assign full     = (cnt_q >= CntWidth'(MaxOutstanding));

  // x0 never creates a hazard even though its bit is tracked like any other.
  always_comb begin
    hazard = chk_vld & sb_q[chk_idx] & (chk_idx != '0);
    for (int i = 0; i < NumSrcRegs; i++) begin
      if (rs_use[i] && (rs[i*RegIdxWidth +: RegIdxWidth] != '0) &&
          sb_q[rs[i*RegIdxWidth +: RegIdxWidth]]) begin
        hazard = 1'b1;
      end
    end
  end

  always_comb begin
    sb_d = sb_q;
    if (clr) sb_d = sb_d & ~reg_mask(clr_idx);
    if (set) sb_d = sb_d | reg_mask(set_idx);
  end

  // Spurious responses (bit already clear) leave the count alone.
  assign cnt_inc = set;
  assign cnt_dec = clr & clr_hit & (cnt_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q <= sb_d;
      if (cnt_inc && !cnt_dec) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end else if (cnt_dec && !cnt_inc) begin
        cnt_q <= cnt_q - CntWidth'(1);
      end
    end
  end

endmodule

// File: rtl/snitch_acc_offload.sv
// Core-side accelerator offload initiator: registered q-stage (1-cycle issue), scoreboard, p-to-writeback pass-through.
// Optional perf counters are enabled with SNITCH_ACC_OFFLOAD_PERF_EN.
module snitch_acc_offload
  import snitch_acc_pkg::*;
#(
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               off_valid_i,
  output logic               off_ready_o,
  input  logic [31:0]        off_instr_i,
  input  logic [31:0]        off_arga_i,
  input  logic [31:0]        off_argb_i,
  input  logic [31:0]        off_argc_i,
  input  logic [4:0]         off_rd_i,
  input  logic [14:0]        hz_rs_i,
  input  logic [2:0]         hz_use_i,
  output logic               hz_stall_o,
  output logic [31:0]        acc_qaddr_o,
  output logic [IdWidth-1:0] acc_qid_o,
  output logic [31:0]        acc_qdata_op_o,
  output logic [31:0]        acc_qdata_arga_o,
  output logic [31:0]        acc_qdata_argb_o,
  output logic [31:0]        acc_qdata_argc_o,
  output logic               acc_qvalid_o,
  input  logic               acc_qready_i,
  input  logic [31:0]        acc_pdata_i,
  input  logic [IdWidth-1:0] acc_pid_i,
  input  logic               acc_perror_i,
  input  logic               acc_pvalid_i,
  output logic               acc_pready_o,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic [4:0]         wb_rd_o,
  output logic [31:0]        wb_data_o,
  output logic               err_o
`ifdef SNITCH_ACC_OFFLOAD_PERF_EN
  ,
  output logic [31:0]        perf_issued_o,
  output logic [31:0]        perf_stall_o
`endif
);

  acc_req_t q_req;
  acc_req_t new_req;
  acc_rsp_t rsp;
  logic     q_vld;
  logic     can_load;
  logic     issue;
  logic     retire;
  logic     rd_busy;
  logic     rsp_known;
  logic     full;
  logic     pid_hi;

  assign new_req = '{
    addr:      32'h0,
    id:        off_rd_i,
    data_op:   off_instr_i,
    data_arga: off_arga_i,
    data_argb: off_argb_i,
    data_argc: off_argc_i
  };

  assign rsp = '{data: acc_pdata_i, id: acc_pid_i[RegIdxWidth-1:0], error: acc_perror_i};

  generate
    if (IdWidth > RegIdxWidth) begin : g_pid_hi
      assign pid_hi = |acc_pid_i[IdWidth-1:RegIdxWidth];
    end else begin : g_no_pid_hi
      assign pid_hi = 1'b0;
    end
  endgenerate

  assign can_load    = !q_vld | acc_qready_i;
  assign off_ready_o = can_load & !rd_busy & !full & !hz_stall_o;
  assign issue       = off_valid_i & off_ready_o;
  assign retire      = acc_pvalid_i & wb_ready_i;

  snitch_acc_scoreboard #(
    .MaxOutstanding (MaxOutstanding)
  ) i_scoreboard (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .set      (issue),
    .set_idx  (off_rd_i),
    .clr      (retire),
    .clr_idx  (rsp.id),
    .rs       (hz_rs_i),
    .rs_use   (hz_use_i),
    .chk_vld  (off_valid_i),
    .chk_idx  (off_rd_i),
    .chk_busy (rd_busy),
    .clr_hit  (rsp_known),
    .hazard   (hz_stall_o),
    .full     (full)
  );

  // Payload only moves on a load, so it is stable while stalled on acc_qready_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_vld <= 1'b0;
      q_req <= '0;
    end else if (issue) begin
      q_vld <= 1'b1;
      q_req <= new_req;
    end else if (acc_qready_i) begin
      q_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (retire && (rsp.error || !rsp_known || pid_hi)) begin
      err_o <= 1'b1;
    end
  end

  assign acc_qvalid_o     = q_vld;
  assign acc_qaddr_o      = q_req.addr;
  assign acc_qid_o        = IdWidth'(q_req.id);
  assign acc_qdata_op_o   = q_req.data_op;
  assign acc_qdata_arga_o = q_req.data_arga;
  assign acc_qdata_argb_o = q_req.data_argb;
  assign acc_qdata_argc_o = q_req.data_argc;

  assign wb_valid_o   = acc_pvalid_i;
  assign acc_pready_o = wb_ready_i;
  assign wb_rd_o      = rsp.id;
  assign wb_data_o    = rsp.data;

`ifdef SNITCH_ACC_OFFLOAD_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (q_vld && acc_qready_i) perf_issued_o <= perf_issued_o + 32'd1;
      if (off_valid_i && !off_ready_o) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snitch_acc_offload.sv
// Bench for snitch_acc_offload: directed sequences, a hazard vector table and a randomized phase
// checked against a queue/array reference of the offload rules.
module tb_snitch_acc_offload;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        off_valid_i;
  logic        off_ready_o;
  logic [31:0] off_instr_i, off_arga_i, off_argb_i, off_argc_i;
  logic [4:0]  off_rd_i;
  logic [14:0] hz_rs_i;
  logic [2:0]  hz_use_i;
  logic        hz_stall_o;
  logic [31:0] acc_qaddr_o;
  logic [4:0]  acc_qid_o;
  logic [31:0] acc_qdata_op_o, acc_qdata_arga_o, acc_qdata_argb_o, acc_qdata_argc_o;
  logic        acc_qvalid_o;
  logic        acc_qready_i;
  logic [31:0] acc_pdata_i;
  logic [4:0]  acc_pid_i;
  logic        acc_perror_i;
  logic        acc_pvalid_i;
  logic        acc_pready_o;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  snitch_acc_offload #(.IdWidth(5), .MaxOutstanding(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .off_valid_i(off_valid_i), .off_ready_o(off_ready_o), .off_instr_i(off_instr_i),
    .off_arga_i(off_arga_i), .off_argb_i(off_argb_i), .off_argc_i(off_argc_i), .off_rd_i(off_rd_i),
    .hz_rs_i(hz_rs_i), .hz_use_i(hz_use_i), .hz_stall_o(hz_stall_o),
    .acc_qaddr_o(acc_qaddr_o), .acc_qid_o(acc_qid_o), .acc_qdata_op_o(acc_qdata_op_o),
    .acc_qdata_arga_o(acc_qdata_arga_o), .acc_qdata_argb_o(acc_qdata_argb_o),
    .acc_qdata_argc_o(acc_qdata_argc_o), .acc_qvalid_o(acc_qvalid_o), .acc_qready_i(acc_qready_i),
    .acc_pdata_i(acc_pdata_i), .acc_pid_i(acc_pid_i), .acc_perror_i(acc_perror_i),
    .acc_pvalid_i(acc_pvalid_i), .acc_pready_o(acc_pready_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .err_o(err_o)
  );

  localparam logic [31:0] MulOp = 32'h0200_0033;
  localparam logic [31:0] DivOp = 32'h0200_4033;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0] rs1, rs2, rs3;
    logic [2:0] uses;
    logic       ov;
    logic [4:0] rd;
    logic       stall;
    logic       rdy;
  } hz_vec_t;

  hz_vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    off_valid_i = 0; off_instr_i = 0; off_arga_i = 0; off_argb_i = 0; off_argc_i = 0; off_rd_i = 0;
    hz_rs_i = 0; hz_use_i = 0; acc_qready_i = 1; acc_pdata_i = 0; acc_pid_i = 0;
    acc_perror_i = 0; acc_pvalid_i = 0; wb_ready_i = 1;
  endtask

  task automatic offer(input logic [4:0] rd, input logic [31:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    off_valid_i = 1; off_rd_i = rd; off_instr_i = op | (32'(rd) << 7);
    off_arga_i = a; off_argb_i = b; off_argc_i = a ^ b;
  endtask

  task automatic respond_cycle(input logic [4:0] pid, input logic [31:0] data);
    acc_pvalid_i = 1; acc_pid_i = pid; acc_pdata_i = data; wb_ready_i = 1;
    tick();
    acc_pvalid_i = 0;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    tick();
    tick();
    rst_ni = 1;
    tick();
  endtask

  // Reference state for the randomized phase.
  bit         pend[32];
  int         mcnt;
  bit         mqv;
  logic [4:0] mqid;
  logic [31:0] mqa;
  int         inflight[$];

  initial begin
    tbl[0] = '{5'd8, 5'd0, 5'd0, 3'b001, 1'b0, 5'd3, 1'b1, 1'b0};
    tbl[1] = '{5'd8, 5'd0, 5'd0, 3'b000, 1'b0, 5'd3, 1'b0, 1'b1};
    tbl[2] = '{5'd0, 5'd0, 5'd8, 3'b100, 1'b0, 5'd3, 1'b1, 1'b0};
    tbl[3] = '{5'd0, 5'd0, 5'd8, 3'b011, 1'b0, 5'd3, 1'b0, 1'b1};
    tbl[4] = '{5'd0, 5'd0, 5'd0, 3'b111, 1'b0, 5'd3, 1'b0, 1'b1};
    tbl[5] = '{5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd8, 1'b1, 1'b0};
    tbl[6] = '{5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd0, 1'b0, 1'b0};
    tbl[7] = '{5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd8, 1'b0, 1'b0};
    tbl[8] = '{5'd0, 5'd8, 5'd0, 3'b010, 1'b0, 5'd3, 1'b1, 1'b0};
    tbl[9] = '{5'd9, 5'd9, 5'd9, 3'b111, 1'b1, 5'd9, 1'b0, 1'b1};

    idle();
    rst_ni = 0;
    #1;
    do_reset();

    // Reset state
    chk("rst_qvalid", acc_qvalid_o, 0);
    chk("rst_qid", acc_qid_o, 0);
    chk("rst_qop", acc_qdata_op_o, 0);
    chk("rst_qaddr", acc_qaddr_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_wbvalid", wb_valid_o, 0);

    // Single issue and writeback
    offer(5, MulOp, 3, 7);
    #2 chk("s1_ready", off_ready_o, 1);
    tick();
    off_valid_i = 0;
    #2;
    chk("s1_qvalid", acc_qvalid_o, 1);
    chk("s1_qid", acc_qid_o, 5);
    chk("s1_arga", acc_qdata_arga_o, 3);
    chk("s1_argb", acc_qdata_argb_o, 7);
    chk("s1_op", acc_qdata_op_o, MulOp | (32'd5 << 7));
    chk("s1_qaddr", acc_qaddr_o, 0);
    tick();
    #2 chk("s1_qdrain", acc_qvalid_o, 0);
    acc_pvalid_i = 1; acc_pid_i = 5; acc_pdata_i = 21;
    #1;
    chk("s1_wbvalid", wb_valid_o, 1);
    chk("s1_wbrd", wb_rd_o, 5);
    chk("s1_wbdata", wb_data_o, 21);
    chk("s1_pready", acc_pready_o, 1);
    tick();
    acc_pvalid_i = 0;
    offer(5, MulOp, 0, 0);
    #2;
    chk("s1_rd5_free", off_ready_o, 1);
    chk("s1_rd5_nostall", hz_stall_o, 0);
    off_valid_i = 0;
    tick();

    // Backpressure
    acc_qready_i = 0;
    offer(5, MulOp, 11, 12);
    tick();
    offer(6, MulOp, 21, 22);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("bp_qvalid", acc_qvalid_o, 1);
      chk("bp_qid", acc_qid_o, 5);
      chk("bp_arga", acc_qdata_arga_o, 11);
      chk("bp_ready6", off_ready_o, 0);
      tick();
    end
    acc_qready_i = 1;
    #2 chk("bp_ready6_up", off_ready_o, 1);
    tick();
    off_valid_i = 0;
    #2;
    chk("bp_qid6", acc_qid_o, 6);
    chk("bp_arga6", acc_qdata_arga_o, 21);
    tick();
    respond_cycle(5, 1);
    respond_cycle(6, 2);

    // Hazard table with x0 and rd8 pending
    offer(0, MulOp, 1, 1);
    tick();
    offer(8, DivOp, 100, 5);
    tick();
    off_valid_i = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      hz_rs_i = {tbl[i].rs3, tbl[i].rs2, tbl[i].rs1};
      hz_use_i = tbl[i].uses;
      off_valid_i = tbl[i].ov;
      off_rd_i = tbl[i].rd;
      #2;
      chk($sformatf("hz_stall[%0d]", i), hz_stall_o, tbl[i].stall);
      chk($sformatf("hz_ready[%0d]", i), off_ready_o, tbl[i].rdy);
      off_valid_i = 0;
      tick();
    end

    // RAW hazard released only after the writeback completes
    hz_rs_i = {5'd0, 5'd0, 5'd8}; hz_use_i = 3'b001;
    acc_pvalid_i = 1; acc_pid_i = 8; acc_pdata_i = 20; wb_ready_i = 0;
    #2;
    chk("raw_stall_wait", hz_stall_o, 1);
    chk("raw_pready_low", acc_pready_o, 0);
    tick();
    wb_ready_i = 1;
    #2 chk("raw_stall_retire", hz_stall_o, 1);
    tick();
    acc_pvalid_i = 0;
    #2 chk("raw_stall_clear", hz_stall_o, 0);
    hz_use_i = 0;
    respond_cycle(0, 0);

    // Credit limit
    for (int r = 1; r <= 4; r++) begin
      offer(5'(r), MulOp, 32'(r), 1);
      #2 chk("cr_ready", off_ready_o, 1);
      tick();
    end
    offer(10, MulOp, 77, 1);
    #2 chk("cr_full", off_ready_o, 0);
    acc_pvalid_i = 1; acc_pid_i = 2; acc_pdata_i = 2;
    #1 chk("cr_full_retire", off_ready_o, 0);
    tick();
    acc_pvalid_i = 0;
    #2 chk("cr_freed", off_ready_o, 1);
    tick();
    off_valid_i = 0;
    #2;
    chk("cr_qid10", acc_qid_o, 10);
    chk("cr_arga10", acc_qdata_arga_o, 77);
    tick();
    respond_cycle(1, 0);
    respond_cycle(3, 0);
    respond_cycle(4, 0);
    respond_cycle(10, 0);

    // Error and spurious responses
    #2 chk("er_err0", err_o, 0);
    for (int r = 11; r <= 13; r++) begin
      offer(5'(r), MulOp, 0, 0);
      tick();
    end
    off_valid_i = 0;
    tick();
    acc_pvalid_i = 1; acc_pid_i = 9; acc_pdata_i = 32'h99;
    #1;
    chk("er_spur_wbvalid", wb_valid_o, 1);
    chk("er_spur_wbrd", wb_rd_o, 9);
    chk("er_spur_wbdata", wb_data_o, 32'h99);
    tick();
    acc_pvalid_i = 0;
    #2 chk("er_err_set", err_o, 1);
    offer(14, MulOp, 0, 0);
    #1 chk("er_cnt3_ready", off_ready_o, 1);
    tick();
    offer(15, MulOp, 0, 0);
    #2 chk("er_cnt4_full", off_ready_o, 0);
    off_valid_i = 0;
    acc_pvalid_i = 1; acc_pid_i = 11; acc_pdata_i = 5; acc_perror_i = 1;
    #1;
    chk("er_perr_wbvalid", wb_valid_o, 1);
    chk("er_perr_wbrd", wb_rd_o, 11);
    tick();
    acc_pvalid_i = 0; acc_perror_i = 0;
    #2 chk("er_err_sticky", err_o, 1);

    // Reset with requests outstanding and the q slot full
    acc_qready_i = 0;
    offer(15, MulOp, 55, 66);
    tick();
    off_valid_i = 0;
    #1 chk("rr_qvalid_pre", acc_qvalid_o, 1);
    rst_ni = 0;
    #1;
    chk("rr_qvalid", acc_qvalid_o, 0);
    chk("rr_qid", acc_qid_o, 0);
    chk("rr_arga", acc_qdata_arga_o, 0);
    chk("rr_err", err_o, 0);
    tick();
    rst_ni = 1;
    acc_qready_i = 1;
    tick();
    offer(12, MulOp, 3, 4);
    #1 chk("rr_ready", off_ready_o, 1);
    tick();
    off_valid_i = 0;
    #2;
    chk("rr_qvalid_new", acc_qvalid_o, 1);
    chk("rr_qid_new", acc_qid_o, 12);
    respond_cycle(13, 0);
    #2 chk("rr_spur_err", err_o, 1);
    respond_cycle(12, 0);

    // Randomized traffic against the reference model
    idle();
    do_reset();
    for (int k = 0; k < 32; k++) pend[k] = 0;
    mcnt = 0; mqv = 0; mqid = 0; mqa = 0;
    inflight.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      int  pick;
      bit  e_stall, e_ready, ret, iss;
      logic [4:0] rsv[3];
      off_valid_i = 1'($urandom_range(0, 1));
      off_rd_i = 5'($urandom_range(0, 15));
      off_instr_i = $urandom; off_arga_i = $urandom; off_argb_i = $urandom; off_argc_i = $urandom;
      for (int s = 0; s < 3; s++) rsv[s] = 5'($urandom_range(0, 15));
      hz_rs_i = {rsv[2], rsv[1], rsv[0]};
      hz_use_i = 3'($urandom_range(0, 7));
      acc_qready_i = ($urandom_range(0, 3) != 0);
      wb_ready_i = ($urandom_range(0, 3) != 0);
      acc_pdata_i = $urandom;
      pick = -1;
      if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = int'($urandom_range(0, inflight.size() - 1));
        acc_pvalid_i = 1; acc_pid_i = 5'(inflight[pick]);
      end else begin
        acc_pvalid_i = 0; acc_pid_i = 0;
      end
      #2;
      e_stall = 0;
      for (int s = 0; s < 3; s++)
        if (hz_use_i[s] && rsv[s] != 0 && pend[rsv[s]]) e_stall = 1;
      if (off_valid_i && off_rd_i != 0 && pend[off_rd_i]) e_stall = 1;
      e_ready = (!mqv || acc_qready_i) && !pend[off_rd_i] && (mcnt < 4) && !e_stall;
      chk("rnd_stall", hz_stall_o, e_stall);
      chk("rnd_ready", off_ready_o, e_ready);
      chk("rnd_qvalid", acc_qvalid_o, mqv);
      if (mqv) begin
        chk("rnd_qid", acc_qid_o, mqid);
        chk("rnd_arga", acc_qdata_arga_o, mqa);
      end
      chk("rnd_wbvalid", wb_valid_o, acc_pvalid_i);
      if (acc_pvalid_i) chk("rnd_wbrd", wb_rd_o, acc_pid_i);
      chk("rnd_err", err_o, 0);
      ret = acc_pvalid_i && wb_ready_i;
      iss = off_valid_i && e_ready;
      if (ret) begin
        inflight.delete(pick);
        if (pend[acc_pid_i]) mcnt--;
        pend[acc_pid_i] = 0;
      end
      if (mqv && acc_qready_i) inflight.push_back(int'(mqid));
      if (iss) begin
        pend[off_rd_i] = 1; mcnt++;
        mqv = 1; mqid = off_rd_i; mqa = off_arga_i;
      end else if (acc_qready_i) begin
        mqv = 0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
